// File: rtl/mio_arb_pkg.sv
// Shared types and constants for the CPU/DMA memory-bus arbiter.
package mio_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_BUSY_CPU = 3'd1,
    ST_BUSY_DMA = 3'd2,
    ST_RESP_CPU = 3'd3,
    ST_RESP_DMA = 3'd4
  } arb_state_t;

  localparam logic [31:0] ERR_DATA   = 32'hDEAD_BEEF;
  localparam logic [1:0]  GRANT_NONE = 2'b00;
  localparam logic [1:0]  GRANT_CPU  = 2'b01;
  localparam logic [1:0]  GRANT_DMA  = 2'b10;

endpackage

// File: rtl/mio_arbiter.sv
// Two-master (CPU priority, DMA starvation guard) arbiter for one memory/IO
// slave port, with per-access timeout and a registered one-cycle ready pulse.
module mio_arbiter
  import mio_arb_pkg::*;
#(
  parameter int TIMEOUT    = 15,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic [31:0] dma_rdata,
  output logic        dma_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        bus_err,
  output logic [1:0]  grant
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [SW-1:0] S_MAX  = SW'(STARVE_MAX);

  arb_state_t    state_reg, state_next;
  logic [TW-1:0] tcnt_reg;
  logic [SW-1:0] starve_reg;
  logic          we_reg;
  logic [31:0]   addr_reg, wdata_reg;
  logic [31:0]   cpu_rdata_reg, dma_rdata_reg;
  logic          bus_err_reg;

  logic take_cpu, take_dma, ack_take, abort;

  always_comb begin
    state_next = state_reg;
    take_cpu   = 1'b0;
    take_dma   = 1'b0;
    ack_take   = 1'b0;
    abort      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // CPU wins ties unless DMA has already lost STARVE_MAX contested rounds.
        if (cpu_req && (!dma_req || starve_reg != S_MAX)) begin
          take_cpu   = 1'b1;
          state_next = ST_BUSY_CPU;
        end else if (dma_req) begin
          take_dma   = 1'b1;
          state_next = ST_BUSY_DMA;
        end
      end
      ST_BUSY_CPU, ST_BUSY_DMA: begin
        if (mem_ack) begin
          ack_take   = 1'b1;
          state_next = (state_reg == ST_BUSY_CPU) ? ST_RESP_CPU : ST_RESP_DMA;
        end else if (tcnt_reg == T_LAST) begin
          abort      = 1'b1;
          state_next = (state_reg == ST_BUSY_CPU) ? ST_RESP_CPU : ST_RESP_DMA;
        end
      end
      ST_RESP_CPU, ST_RESP_DMA: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      tcnt_reg      <= '0;
      starve_reg    <= '0;
      we_reg        <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      cpu_rdata_reg <= '0;
      dma_rdata_reg <= '0;
      bus_err_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bus_err_reg <= abort;
      if (take_cpu) begin
        we_reg    <= cpu_we;
        addr_reg  <= cpu_addr;
        wdata_reg <= cpu_wdata;
        tcnt_reg  <= '0;
        if (dma_req && starve_reg != S_MAX)
          starve_reg <= starve_reg + 1'b1;
      end else if (take_dma) begin
        we_reg     <= dma_we;
        addr_reg   <= dma_addr;
        wdata_reg  <= dma_wdata;
        tcnt_reg   <= '0;
        starve_reg <= '0;
      end else if (ack_take || abort) begin
        if (state_reg == ST_BUSY_CPU)
          cpu_rdata_reg <= ack_take ? mem_rdata : ERR_DATA;
        else
          dma_rdata_reg <= ack_take ? mem_rdata : ERR_DATA;
      end else if (state_reg == ST_BUSY_CPU || state_reg == ST_BUSY_DMA) begin
        tcnt_reg <= tcnt_reg + 1'b1;
      end
    end
  end

  assign mem_req   = (state_reg == ST_BUSY_CPU) || (state_reg == ST_BUSY_DMA);
  assign mem_we    = we_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign cpu_rdata = cpu_rdata_reg;
  assign dma_rdata = dma_rdata_reg;
  assign cpu_ready = (state_reg == ST_RESP_CPU);
  assign dma_ready = (state_reg == ST_RESP_DMA);
  assign bus_err   = bus_err_reg;
  assign grant     = (state_reg == ST_BUSY_CPU) ? GRANT_CPU :
                     (state_reg == ST_BUSY_DMA) ? GRANT_DMA : GRANT_NONE;

endmodule

// File: tb/tb_mio_arbiter.sv
// Directed, table-driven bench for mio_arbiter: single transactions from a
// vector table, then contention, stray ack, and mid-transaction reset sequences.
module tb_mio_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic [31:0] cpu_rdata, dma_rdata;
  logic        cpu_ready, dma_ready;
  logic        mem_req, mem_we, mem_ack, bus_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  grant;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mio_arbiter #(.TIMEOUT(15), .STARVE_MAX(3)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ready(dma_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err), .grant(grant)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        is_dma;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ack_cyc;    // 0 = slave never acks
    logic [31:0] rdata;
    int          exp_ready;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t        vecs[7];
  vec_t        v;
  logic [1:0]  order[9];
  logic [31:0] own_rdata;
  logic        own_ready, oth_ready;
  bit          done;
  int          busy_cnt, ng;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,          1,  32'h1234_5678, 2,  1'b0, 32'h1234_5678};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_2000, 32'hA5A5_0001,  3,  32'h0000_0000, 4,  1'b0, 32'h0000_0000};
    vecs[2] = '{1'b0, 1'b1, 32'h0000_0044, 32'h5555_AAAA,  2,  32'h0000_0077, 3,  1'b0, 32'h0000_0077};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_3004, 32'h0,          1,  32'hCAFE_0001, 2,  1'b0, 32'hCAFE_0001};
    vecs[4] = '{1'b0, 1'b0, 32'h0000_0080, 32'h0,          0,  32'h0,         16, 1'b1, 32'hDEAD_BEEF};
    vecs[5] = '{1'b0, 1'b0, 32'h0000_0084, 32'h0,          15, 32'h0000_00FF, 16, 1'b0, 32'h0000_00FF};
    vecs[6] = '{1'b1, 1'b0, 32'h0000_3008, 32'h0,          0,  32'h0,         16, 1'b1, 32'hDEAD_BEEF};
    order = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};

    reset = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
    mem_ack = 0; mem_rdata = 0;
    repeat (3) @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_grant", grant, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_dma_rdata", dma_rdata, 0);
    check("rst_readies", {cpu_ready, dma_ready, bus_err}, 0);
    reset = 1'b1;

    for (int i = 0; i < 7; i++) begin
      v = vecs[i];
      @(negedge clk);
      if (v.is_dma) begin
        dma_req = 1; dma_we = v.we; dma_addr = v.addr; dma_wdata = v.wdata;
      end else begin
        cpu_req = 1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
      end
      done = 0;
      busy_cnt = 0;
      for (int c = 1; c <= 40 && !done; c++) begin
        @(negedge clk);
        own_ready = v.is_dma ? dma_ready : cpu_ready;
        oth_ready = v.is_dma ? cpu_ready : dma_ready;
        own_rdata = v.is_dma ? dma_rdata : cpu_rdata;
        if (c == 1) begin
          check("grant_c1", grant, v.is_dma ? 2'b10 : 2'b01);
          check("mem_addr_c1", mem_addr, v.addr);
          check("mem_we_c1", mem_we, v.we);
          check("mem_wdata_c1", mem_wdata, v.wdata);
        end
        if (mem_req) busy_cnt++;
        check("bus_err", bus_err, v.exp_err && (c == v.exp_ready));
        check("own_ready", own_ready, c == v.exp_ready);
        check("other_ready", oth_ready, 0);
        if (c == v.exp_ready) begin
          check("rdata", own_rdata, v.exp_rdata);
          check("mem_req_cycles", busy_cnt, v.exp_ready - 1);
          check("mem_req_in_resp", mem_req, 0);
          cpu_req = 0; dma_req = 0;
          done = 1;
        end
        mem_ack   = (c == v.ack_cyc);
        mem_rdata = (c == v.ack_cyc) ? v.rdata : 32'h0BAD_0BAD;
      end
      mem_ack = 0;
      if (!done) begin
        n_checks++; n_errors++;
        $display("FAIL txn%0d_timeout: got no ready required ready in cycle %0d", i, v.exp_ready);
        cpu_req = 0; dma_req = 0;
      end
      $display("txn %0d %s we=%0d addr=%h rdata=%h bus_err_expected=%0d", i,
               v.is_dma ? "DMA" : "CPU", v.we, v.addr, v.exp_rdata, v.exp_err);
    end

    // Contention with a zero-wait slave: order must cycle CPU x3, DMA.
    @(negedge clk);
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h100;
    dma_req = 1; dma_we = 0; dma_addr = 32'h200;
    ng = 0;
    for (int c = 0; c < 60 && ng < 9; c++) begin
      @(negedge clk);
      if (mem_req) begin
        check("contention_grant", grant, order[ng]);
        check("contention_addr", mem_addr, (order[ng] == 2'b01) ? 32'h100 : 32'h200);
        $display("contention grant %0d: %b", ng, grant);
        ng++;
      end
      mem_ack = mem_req;
      mem_rdata = 32'h0000_1111;
    end
    if (ng < 9) begin
      n_checks++; n_errors++;
      $display("FAIL contention_timeout: got %0d grants required 9", ng);
    end
    cpu_req = 0; dma_req = 0;
    @(negedge clk);
    mem_ack = 0;
    repeat (2) @(negedge clk);

    // Ack while idle must be ignored.
    mem_ack = 1; mem_rdata = 32'h9999_9999;
    @(negedge clk);
    mem_ack = 0;
    for (int c = 0; c < 3; c++) begin
      check("stray_ack_quiet", {mem_req, cpu_ready, dma_ready, bus_err}, 0);
      @(negedge clk);
    end
    $display("stray ack while idle ignored-check done");

    // Reset during a pending DMA access.
    dma_req = 1; dma_we = 1; dma_addr = 32'h4000; dma_wdata = 32'h1;
    @(negedge clk);
    check("rst_pre_mem_req", mem_req, 1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_mid_mem_req", mem_req, 0);
    check("rst_mid_grant", grant, 0);
    check("rst_mid_dma_ready", dma_ready, 0);
    check("rst_mid_mem_addr", mem_addr, 0);
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h500;
    @(negedge clk);
    check("rst_hold_dma_ready", dma_ready, 0);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_grant", grant, 2'b01);
    check("post_rst_addr", mem_addr, 32'h500);
    cpu_req = 0; dma_req = 0;
    mem_ack = 1; mem_rdata = 32'h0000_0ABC;
    @(negedge clk);
    mem_ack = 0;
    check("post_rst_cpu_ready", cpu_ready, 1);
    check("post_rst_cpu_rdata", cpu_rdata, 32'h0000_0ABC);
    $display("reset mid-busy sequence done");
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
